key_repeat: RTL and testbench

- Sits directly downstream of the per-button debouncers. Consumes their clean level outputs for the game controls (left, right, down, rotate).
- Converts each held level into game-input events:
  - one single-cycle pulse on press;
  - optionally, auto-repeat pulses after an initial hold delay, then at a fixed repeat period.
- Pulses feed the Tetris game-logic FSM.

---
 rtl/key_repeat_pkg.sv | 17 +
 rtl/key_repeat_chan.sv | 107 ++++++++++
 rtl/key_repeat.sv | 73 +++++++
 tb/tb_key_repeat.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/key_repeat_pkg.sv
// key_repeat_pkg: shared definitions for the key press / auto-repeat block.
//   state_t          per-channel FSM state encoding
//   KEY_*            key channel index assignments for the game controls
package key_repeat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  localparam int unsigned KEY_LEFT  = 0;
  localparam int unsigned KEY_RIGHT = 1;
  localparam int unsigned KEY_DOWN  = 2;
  localparam int unsigned KEY_ROT   = 3;

endpackage

// File: rtl/key_repeat_chan.sv
// key_repeat_chan: one key channel. Emits a single-cycle pulse on press and,
// if enabled, auto-repeat pulses after an initial hold delay, counted in ticks.
// Ports:
//   Clk, Reset       clock, asynchronous active-high reset
//   i_enable         0 forces IDLE and suppresses pulses
//   i_tick           shared timebase tick
//   i_key            debounced key level, 1 = pressed
//   o_pulse          registered one-cycle event
//   o_pulse_nxt_c    combinational next value of o_pulse
module key_repeat_chan
  import key_repeat_pkg::*;
#(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned INIT_DELAY    = 170,
  parameter int unsigned REPEAT_PERIOD = 50,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_enable,
  input  logic i_tick,
  input  logic i_key,
  output logic o_pulse,
  output logic o_pulse_nxt_c
);

  localparam logic [CNT_W-1:0] INIT_M1 = CNT_W'(INIT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_PERIOD - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_key_q;
  logic             w_rise;
  logic             w_active;
  logic             w_hold_end;
  logic             w_rep_end;

  assign w_rise     = i_key & ~r_key_q;
  assign w_active   = i_enable & i_key;
  assign w_hold_end = (r_cnt == INIT_M1);
  assign w_rep_end  = (r_cnt == REP_M1);

  // Next pulse value; shared with the top so AnyPulse aligns with KeyPulse.
  always_comb begin
    o_pulse_nxt_c = 1'b0;
    if (w_active) begin
      case (r_state)
        ST_IDLE:   o_pulse_nxt_c = w_rise;
        ST_HOLD:   o_pulse_nxt_c = i_tick & w_hold_end & REPEAT_EN;
        ST_REPEAT: o_pulse_nxt_c = i_tick & w_rep_end;
        default:   o_pulse_nxt_c = 1'b0;
      endcase
    end
  end

  // Channel FSM and tick counter. key_q tracks the key even while disabled,
  // so re-enabling with a key held does not look like a fresh press.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_key_q <= 1'b0;
      o_pulse <= 1'b0;
    end else begin
      r_key_q <= i_key;
      o_pulse <= o_pulse_nxt_c;
      if (!w_active) begin
        // Release (or disable) wins over any coincident fire tick.
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              r_state <= ST_HOLD;
              r_cnt   <= '0;
            end
          end
          ST_HOLD: begin
            if (i_tick) begin
              if (w_hold_end) begin
                if (REPEAT_EN) begin
                  r_state <= ST_REPEAT;
                  r_cnt   <= '0;
                end
                // Non-repeating keys park here with the counter saturated.
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          ST_REPEAT: begin
            if (i_tick) begin
              if (w_rep_end) r_cnt <= '0;
              else           r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/key_repeat.sv
// key_repeat: converts debounced key levels into press and auto-repeat pulses
// for the game logic. One shared free-running prescaler provides the tick.
// Ports:
//   Clk, Reset   clock, asynchronous active-high reset
//   Enable       0 forces all channels idle, no pulses, KeyHeld cleared
//   KeyIn        debounced key levels, 1 = pressed
//   KeyPulse     one-cycle event per key (press or repeat)
//   KeyHeld      registered KeyIn gated by Enable
//   AnyPulse     registered OR of all KeyPulse bits, same cycle as KeyPulse
module key_repeat
  import key_repeat_pkg::*;
#(
  parameter int unsigned       NKEYS         = 4,
  parameter int unsigned       TICK_DIV      = 50000,
  parameter int unsigned       CNT_W         = 8,
  parameter int unsigned       INIT_DELAY    = 170,
  parameter int unsigned       REPEAT_PERIOD = 50,
  parameter logic [NKEYS-1:0]  REPEAT_MASK   = NKEYS'(4'b0111)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [NKEYS-1:0] KeyIn,
  output logic [NKEYS-1:0] KeyPulse,
  output logic [NKEYS-1:0] KeyHeld,
  output logic             AnyPulse
);

  localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PS_W-1:0]  r_ps;
  logic             w_tick;
  logic [NKEYS-1:0] w_pulse_nxt;

  // With TICK_DIV=1 the terminal count is 0 and the tick is constant.
  assign w_tick = (r_ps == PS_W'(TICK_DIV - 1));

  // Shared timebase prescaler.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       r_ps <= '0;
    else if (w_tick) r_ps <= '0;
    else             r_ps <= r_ps + PS_W'(1);
  end

  for (genvar g = 0; g < NKEYS; g++) begin : g_chan
    key_repeat_chan #(
      .CNT_W         (CNT_W),
      .INIT_DELAY    (INIT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .REPEAT_EN     (REPEAT_MASK[g])
    ) u_chan (
      .Clk           (Clk),
      .Reset         (Reset),
      .i_enable      (Enable),
      .i_tick        (w_tick),
      .i_key         (KeyIn[g]),
      .o_pulse       (KeyPulse[g]),
      .o_pulse_nxt_c (w_pulse_nxt[g])
    );
  end

  // Held levels and the combined event flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      KeyHeld  <= '0;
      AnyPulse <= 1'b0;
    end else begin
      KeyHeld  <= Enable ? KeyIn : '0;
      AnyPulse <= |w_pulse_nxt;
    end
  end

endmodule

// File: tb/tb_key_repeat.sv
// tb_key_repeat: directed bench for key_repeat. dut_a uses TICK_DIV=1,
// INIT_DELAY=3, REPEAT_PERIOD=2; dut_b uses TICK_DIV=4, INIT_DELAY=2.
// Expected {AnyPulse, KeyHeld, KeyPulse} is queued as each input is driven
// and popped for comparison after the clock edge that consumes it.
module tb_key_repeat;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_en, b_en;
  logic [3:0] a_key, b_key;
  logic [3:0] a_pulse, a_held, b_pulse, b_held;
  logic       a_any, b_any;

  int         checks   = 0;
  int         failures = 0;
  logic [8:0] q_exp[$];

  always #5 clk = ~clk;

  key_repeat #(
    .NKEYS(4), .TICK_DIV(1), .CNT_W(8), .INIT_DELAY(3),
    .REPEAT_PERIOD(2), .REPEAT_MASK(4'b0111)
  ) dut_a (
    .Clk(clk), .Reset(rst), .Enable(a_en), .KeyIn(a_key),
    .KeyPulse(a_pulse), .KeyHeld(a_held), .AnyPulse(a_any)
  );

  key_repeat #(
    .NKEYS(4), .TICK_DIV(4), .CNT_W(8), .INIT_DELAY(2),
    .REPEAT_PERIOD(2), .REPEAT_MASK(4'b0111)
  ) dut_b (
    .Clk(clk), .Reset(rst), .Enable(b_en), .KeyIn(b_key),
    .KeyPulse(b_pulse), .KeyHeld(b_held), .AnyPulse(b_any)
  );

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input logic [3:0] key, input logic [3:0] exp_p, input string tag);
    a_key = key;
    q_exp.push_back({|exp_p, key & {4{a_en}}, exp_p});
    @(posedge clk); #1;
    check(tag, {a_any, a_held, a_pulse}, q_exp.pop_front());
  endtask

  task automatic step_b(input logic [3:0] key, input logic [3:0] exp_p, input string tag);
    b_key = key;
    q_exp.push_back({|exp_p, key & {4{b_en}}, exp_p});
    @(posedge clk); #1;
    check(tag, {b_any, b_held, b_pulse}, q_exp.pop_front());
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    a_en  = 1'b1;
    b_en  = 1'b1;
    a_key = '0;
    b_key = '0;
    #1;
    check("rst_a", {a_any, a_held, a_pulse}, 9'h000);
    check("rst_b", {b_any, b_held, b_pulse}, 9'h000);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: left key held, repeats at +3, +5, +7
    for (int i = 0; i < 9; i++)
      step_a(4'b0001, (i == 0 || i == 3 || i == 5 || i == 7) ? 4'b0001 : 4'b0000,
             $sformatf("t1_%0d", i));
    step_a(4'b0000, 4'b0000, "t1_rel");
    step_a(4'b0000, 4'b0000, "t1_idle");

    // 2: rotate does not repeat
    for (int i = 0; i < 20; i++)
      step_a(4'b1000, (i == 0) ? 4'b1000 : 4'b0000, $sformatf("t2_%0d", i));
    step_a(4'b0000, 4'b0000, "t2_rel");
    step_a(4'b0000, 4'b0000, "t2_idle");

    // 3: release coincident with repeat fire, then re-press
    for (int i = 0; i < 11; i++) begin
      logic [3:0] k;
      logic [3:0] e;
      k = (i >= 5 && i <= 7) ? 4'b0000 : 4'b0010;
      e = (i == 0 || i == 3 || i == 8) ? 4'b0010 : 4'b0000;
      step_a(k, e, $sformatf("t3_%0d", i));
    end
    step_a(4'b0000, 4'b0000, "t3_rel");

    // 4: two keys rising together
    for (int i = 0; i < 6; i++)
      step_a(4'b0011, (i == 0 || i == 3 || i == 5) ? 4'b0011 : 4'b0000,
             $sformatf("t4_%0d", i));
    step_a(4'b0000, 4'b0000, "t4_rel");

    // 5: async reset mid-repeat, key held through reset release
    for (int i = 0; i < 5; i++)
      step_a(4'b0001, (i == 0 || i == 3) ? 4'b0001 : 4'b0000, $sformatf("t5_pre_%0d", i));
    #2 rst = 1'b1;
    #1;
    q_exp.push_back(9'h000);
    check("t5_async", {a_any, a_held, a_pulse}, q_exp.pop_front());
    @(posedge clk); #1;
    check("t5_in_rst", {a_any, a_held, a_pulse}, 9'h000);
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++)
      step_a(4'b0001, (i == 0 || i == 3 || i == 5) ? 4'b0001 : 4'b0000,
             $sformatf("t5_post_%0d", i));
    step_a(4'b0000, 4'b0000, "t5_rel");

    // 6: TICK_DIV=4, first repeat 5..8 cycles after press at varying phases
    for (int p = 0; p < 4; p++) begin
      for (int j = 0; j < p; j++) step_b(4'b0000, 4'b0000, "t6_idle");
      step_b(4'b0001, 4'b0001, $sformatf("t6_press_%0d", p));
      for (int off = 1; off <= 4; off++)
        step_b(4'b0001, 4'b0000, $sformatf("t6_early_%0d_%0d", p, off));
      n = 0;
      for (int off = 5; off <= 8; off++) begin
        b_key = 4'b0001;
        @(posedge clk); #1;
        if (b_pulse[0] === 1'b1) n++;
      end
      check($sformatf("t6_window_%0d", p), 9'(n), 9'd1);
      step_b(4'b0000, 4'b0000, $sformatf("t6_rel_%0d", p));
    end

    // 6: Enable low while held, then high again with key still held
    step_b(4'b0001, 4'b0001, "t6_en_press");
    step_b(4'b0001, 4'b0000, "t6_en_hold");
    b_en = 1'b0;
    for (int i = 0; i < 12; i++) step_b(4'b0001, 4'b0000, $sformatf("t6_dis_%0d", i));
    b_en = 1'b1;
    for (int i = 0; i < 12; i++) step_b(4'b0001, 4'b0000, $sformatf("t6_reen_%0d", i));
    step_b(4'b0000, 4'b0000, "t6_rel");
    step_b(4'b0001, 4'b0001, "t6_repress");
    step_b(4'b0000, 4'b0000, "t6_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
